// File: rtl/slave_request_buffer.sv
// Per-slave request buffer: captures the granted master's request on each
// arbiter push, tags it with the master number and serves entries to the slave in order.
module slave_request_buffer #(
  parameter int masters       = 2,
  parameter int payload_width = 45,
  parameter int depth         = 4
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic                           push_in,
  input  logic [$clog2(masters):0]       grant_master_number,
  input  logic [payload_width-1:0]       master_payload [0:masters-1],
  output logic [masters-1:0]             master_pop,
  output logic                           fifo_full,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [payload_width-1:0]       out_payload,
  output logic [$clog2(masters):0]       out_master,
  output logic [$clog2(depth):0]         count,
  output logic [15:0]                    stall_count
);

  localparam int GW  = $clog2(masters) + 1;
  localparam int GIW = (masters > 1) ? $clog2(masters) : 1;
  localparam int CW  = $clog2(depth) + 1;
  localparam int PW  = (depth > 1) ? $clog2(depth) : 1;
  localparam int EW  = GW + payload_width;

  logic [EW-1:0] mem_q [depth];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   stall_q, stall_d;

  logic           in_range, full, valid, accept, pop;
  logic [GIW-1:0] gidx;
  logic [EW-1:0]  wdata, head;

  assign gidx     = grant_master_number[GIW-1:0];
  assign in_range = grant_master_number < GW'(masters);
  assign full     = count_q == CW'(depth);
  assign valid    = count_q != '0;
  // Reset also suppresses the pop strobe so no master FIFO entry is lost.
  assign accept   = push_in & ~full & in_range & ~ARESET;
  assign pop      = valid & out_ready;
  assign wdata    = {grant_master_number, master_payload[gidx]};
  assign head     = mem_q[rptr_q];

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    stall_d = stall_q;
    if (accept) wptr_d = (wptr_q == PW'(depth - 1)) ? '0 : wptr_q + 1'b1;
    if (pop)    rptr_d = (rptr_q == PW'(depth - 1)) ? '0 : rptr_q + 1'b1;
    case ({accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (push_in && full && in_range && stall_q != 16'hFFFF) stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      stall_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      stall_q <= stall_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge ACLK) begin
    if (accept) mem_q[wptr_q] <= wdata;
  end

  always_comb begin
    master_pop = '0;
    if (accept) master_pop = masters'(1) << gidx;
  end

  assign fifo_full   = full;
  assign out_valid   = valid;
  assign out_payload = valid ? head[payload_width-1:0] : '0;
  assign out_master  = valid ? head[EW-1:payload_width] : '0;
  assign count       = count_q;
  assign stall_count = stall_q;

endmodule

// File: doc/slave_request_buffer.md
Name: slave_request_buffer

Overview:
Per-slave request buffer that sits directly downstream of the per-slave forward arbiter in the crossbar.
- On each arbiter push it captures the granted master's request payload and tags it with the master number.
- It pops the granted master's request FIFO and queues the entry for the slave port.
- It presents queued entries to the slave side over a valid/ready handshake.
- Its full flag drives the arbiter's slave-FIFO-full input.

Parameters:
masters, 2, number of master ports (>=2)
payload_width, 45, request payload bits per master (AW/AR channel bundle)
depth, 4, buffer entries (>=2, any integer, not necessarily a power of 2)

Ports:
ACLK  in  1  clock, all logic on rising edge
ARESET  in  1  synchronous, active-high reset
push_in  in  1  push request from arbiter
grant_master_number  in  $clog2(masters)+1  granted master index from arbiter
master_payload  in  payload_width x masters (unpacked [0:masters-1])  head entry of each master request FIFO
master_pop  out  masters  one-hot pop strobe to master request FIFOs
fifo_full  out  1  buffer full, to arbiter
out_valid  out  1  entry available to slave
out_ready  in  1  slave accepts entry
out_payload  out  payload_width  head entry payload
out_master  out  $clog2(masters)+1  head entry master tag
count  out  $clog2(depth)+1  current occupancy
stall_count  out  16  saturating count of rejected pushes

Behaviour:
- Reset (ARESET=1 at a rising ACLK edge):
  - write pointer, read pointer, count and stall_count go to 0.
  - Storage contents are not reset.
  - Outputs after reset: out_valid=0, fifo_full=0, master_pop=0, out_payload=0, out_master=0.
  - Reset wins over any push or pop in the same cycle; no entry is written or consumed.
- Push accepted: accept = push_in & ~fifo_full & (grant_master_number < masters).
- On accept:
  - At the next edge, mem[wptr] <= {grant_master_number, master_payload[grant_master_number]}.
  - wptr advances.
- master_pop[g] is combinational: it is asserted in the same cycle as accept, for g = grant_master_number only.
  - All other bits are 0.
  - master_pop is 0 whenever accept=0.
- Out-of-range grant (>= masters) with push_in=1: ignored. No write, no pop, no stall count.
- Rejected push (push_in=1, fifo_full=1, grant in range): no write, no pop, stall_count += 1, saturating at 16'hFFFF.
  - The arbiter may assert push_in while fifo_full=1; the buffer rejects it as above.
- Pop: pop = out_valid & out_ready. On pop, rptr advances at the next edge.
- Pointer wrap: pointers wrap from depth-1 to 0 explicitly (no power-of-2 assumption).
- count: +1 on accept only, -1 on pop only, unchanged when both or neither occur.
- Status outputs (derived from registered state only):
  - fifo_full = (count == depth).
  - out_valid = (count != 0).
- Head outputs:
  - out_payload and out_master = mem[rptr] when out_valid=1.
  - They are forced to 0 when out_valid=0.
  - They hold stable while out_valid=1 and out_ready=0.
- Latency: an accepted push is visible on out_valid at the next cycle. There is no fall-through when empty.
- Simultaneous push and pop:
  - When full: the push is rejected (fifo_full is from registered count, no bypass); the pop proceeds. Next cycle count = depth-1.
  - When 0 < count < depth: both occur and count is unchanged.
  - When empty: out_valid=0, so no pop. The push is stored.
- out_ready while empty: no effect. count never underflows.
- Ordering: entries leave strictly in acceptance order.

Test Plan:
- Reset then idle: ARESET=1 for 2 cycles, then push_in=0 -> out_valid=0, fifo_full=0, count=0, master_pop=2'b00, stall_count=0.
- Single transfer, masters=2:
  - push_in=1, grant=1, master_payload[1]=45'h1ABCD -> master_pop=2'b10 in the same cycle.
  - Next cycle: out_valid=1, out_payload=45'h1ABCD, out_master=1.
  - out_ready=1 -> following cycle out_valid=0, count=0.
- Fill and reject, depth=4, out_ready=0:
  - 4 pushes (grants 0,1,0,1, payloads 1..4) -> fifo_full=1, count=4.
  - A 5th push -> master_pop=0, stall_count=1, contents unchanged.
  - Drain -> payloads 1,2,3,4 with tags 0,1,0,1 in order.
- Full with simultaneous push and pop: count=4, push_in=1, out_ready=1 -> push rejected, stall_count+1, count=3 next cycle, head advances by one.
- Streaming wrap: continuous push and out_ready=1 for 10 entries, depth=4 -> count stays at 1 after the first cycle, all 10 payloads delivered in order, pointers wrap twice, stall_count=0.
- Invalid grant and mid-operation reset:
  - push_in=1, grant=2 (masters=2) -> no pop, no write, stall_count unchanged.
  - With count=3, assert ARESET for one cycle together with push_in=1 and out_ready=1 -> next cycle count=0, out_valid=0, stall_count=0, master_pop=0 during reset.
